// File: rtl/sub_pipe_if.sv
// Valid/ready handshake bundle for the two-stage subtractor: operand side
// (a, b) and result side (out, borrow).
interface sub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, borrow
  );
endinterface

// File: rtl/sub_pipe.sv
// Two-stage elastic subtractor: S1 holds operands, S2 holds a - b and borrow.
// Each stage advances when the stage ahead is free; out_ready feeds in_ready.
module sub_pipe #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         arst,
  sub_pipe_if.slave   bus
);

  logic [WIDTH-1:0] a_r, b_r;
  logic             v1;
  logic [WIDTH-1:0] out_r;
  logic             borrow_r;
  logic             v2;

  logic             s2_free, s1_free;
  logic             in_fire, s1_move;
  logic [WIDTH:0]   diff;

  assign s2_free = ~v2 | bus.out_ready;
  assign s1_free = ~v1 | s2_free;
  assign in_fire = bus.in_valid & s1_free;
  assign s1_move = v1 & s2_free;

  // Extra top bit of the widened difference is the unsigned borrow.
  assign diff = {1'b0, a_r} - {1'b0, b_r};

  assign bus.in_ready  = s1_free;
  assign bus.out_valid = v2;
  assign bus.out       = out_r;
  assign bus.borrow    = borrow_r;

  // NOTE: data registers are cleared with the valids so out/borrow read 0
  // during and right after reset, not just whatever was in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_r      <= '0;
      b_r      <= '0;
      v1       <= 1'b0;
      out_r    <= '0;
      borrow_r <= 1'b0;
      v2       <= 1'b0;
    end else begin
      // NOTE: non-blocking so S2 captures the S1 contents from before this
      // edge even when S1 reloads on the same edge.
      if (in_fire) begin
        a_r <= bus.a;
        b_r <= bus.b;
      end
      if (s1_move) begin
        out_r    <= diff[WIDTH-1:0];
        borrow_r <= diff[WIDTH];
      end

      if (in_fire)      v1 <= 1'b1;
      else if (s1_move) v1 <= 1'b0;

      if (s1_move)            v2 <= 1'b1;
      else if (bus.out_ready) v2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub_pipe.sv
// Directed self-checking bench for sub_pipe: reset, single ops, wrap/borrow,
// backpressure, full throughput and reset in the middle of a stall.
module tb_sub_pipe;
  localparam int W = 16;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sub_pipe_if #(.WIDTH(W)) bus ();

  sub_pipe #(.WIDTH(W)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pair through an otherwise idle pipe with out_ready held high.
  task automatic run_one(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eo, input logic eb);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 16'hdead;
    bus.b        = 16'h0bad;
    #1;
    check({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    #1;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out"}, 32'(bus.out), 32'(eo));
    check({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
    tick();
    #1;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [W-1:0] bp_a [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
  logic [W-1:0] bp_b [4] = '{16'd3, 16'd5, 16'd7, 16'd9};
  logic [W-1:0] bp_e [4] = '{16'd7, 16'd15, 16'd23, 16'd31};

  logic [W-1:0] ft_a [16] = '{16'h0001, 16'h8000, 16'h1234, 16'h0000,
                              16'hffff, 16'h7fff, 16'h00ff, 16'habcd,
                              16'h0010, 16'hc350, 16'h0400, 16'h5555,
                              16'h0002, 16'hfffe, 16'h3c3c, 16'h9999};
  logic [W-1:0] ft_b [16] = '{16'h0001, 16'h0001, 16'h4321, 16'hffff,
                              16'h0000, 16'h8000, 16'h00fe, 16'h1234,
                              16'h0011, 16'h2710, 16'h0400, 16'haaaa,
                              16'h0003, 16'h0001, 16'h3c3c, 16'h1111};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idx;
    int got;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset asserted between edges must take effect immediately.
    #2 arst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_borrow", 32'(bus.borrow), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 arst = 1'b0;

    run_one("single", 16'h1234, 16'h0034, 16'h1200, 1'b0);
    run_one("wrap", 16'h0000, 16'h0001, 16'hffff, 1'b1);
    run_one("equal", 16'hffff, 16'hffff, 16'h0000, 1'b0);

    // Backpressure: two accepts fill both stages, then in_ready drops.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = bp_a[0]; bus.b = bp_b[0];
    #1;
    check("bp_accept0", 32'(bus.in_ready), 32'd1);
    tick();
    bus.a = bp_a[1]; bus.b = bp_b[1];
    #1;
    check("bp_accept1", 32'(bus.in_ready), 32'd1);
    tick();
    bus.a = bp_a[2]; bus.b = bp_b[2];
    #1;
    check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_full_valid", 32'(bus.out_valid), 32'd1);
    check("bp_full_out", 32'(bus.out), 32'd7);
    repeat (3) begin
      tick();
      #1;
      check("bp_hold_out", 32'(bus.out), 32'd7);
      check("bp_hold_borrow", 32'(bus.borrow), 32'd0);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    idx = 2;
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (bus.out_valid) begin
        check("bp_result", 32'(bus.out), 32'(bp_e[got]));
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
      if (idx < 4) begin
        bus.a = bp_a[idx];
        bus.b = bp_b[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
    end
    check("bp_count", 32'(got), 32'd4);
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Full throughput: result for pair k is presented two cycles after it is driven.
    bus.out_ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      if (c < 16) begin
        bus.in_valid = 1'b1;
        bus.a = ft_a[c];
        bus.b = ft_b[c];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c < 16) check("ft_in_ready", 32'(bus.in_ready), 32'd1);
      check("ft_valid", 32'(bus.out_valid), 32'((c >= 2) && (c < 18)));
      if (c >= 2 && c < 18) begin
        check("ft_out", 32'(bus.out), 32'(W'(ft_a[c-2] - ft_b[c-2])));
        check("ft_borrow", 32'(bus.borrow), 32'(ft_a[c-2] < ft_b[c-2]));
      end
      tick();
    end

    // Reset in the middle of a full stall discards everything in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 16'd100; bus.b = 16'd1;
    tick();
    bus.a = 16'd200; bus.b = 16'd2;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("mid_full_valid", 32'(bus.out_valid), 32'd1);
    check("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_full_out", 32'(bus.out), 32'd99);
    #2 arst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out", 32'(bus.out), 32'd0);
    check("mid_rst_borrow", 32'(bus.borrow), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    #1 arst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      tick();
      #1;
      check("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end
    run_one("post_rst", 16'd5, 16'd2, 16'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
